clause_array_io_ctrl: RTL and testbench

- Controller that sits on the load/update side of a clause array.
- Load: accepts a valid/ready stream of clauses and issues one-hot write strobes plus clause data and length into the array.
- Update: issues one-hot read strobes, captures the OR-reduced clause data and the selected clause-length slice, and emits them as a valid/ready stream.
- Both directions use the same sequencing FSM.

---
 rtl/clause_io_pkg.sv | 36 +++
 rtl/cid_onehot_dec.sv | 31 +++
 rtl/clause_array_io_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_clause_array_io_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_io_pkg.sv
// -----------------------------------------------------------------------------
// clause_io_pkg
// Shared definitions for the clause array load/update controller.
//   - state_e     : sequencing FSM states (IDLE, LOAD, RD, CAP, OUT, DONE)
//   - CLAUSE_W    : default clause word width (2 * default variable count)
//   - RD_LAT      : read latency of the attached clause array, in cycles
//   - clamp_count : limits a requested slot count to the physical slot count
// -----------------------------------------------------------------------------
package clause_io_pkg;

    localparam int NUM_VARS_DEF = 8;
    localparam int CLAUSE_W     = 2 * NUM_VARS_DEF;
    localparam int RD_LAT       = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Returns min(num, max_v).
    function automatic logic [31:0] clamp_count(input logic [31:0] num,
                                                input logic [31:0] max_v);
        logic [31:0] res;
        if (num > max_v) begin
            res = max_v;
        end else begin
            res = num;
        end
        return res;
    endfunction

endpackage

// File: rtl/cid_onehot_dec.sv
// -----------------------------------------------------------------------------
// cid_onehot_dec
// Converts a clause slot index into a one-hot slot strobe.
//   idx_i    : slot index
//   en_i     : strobe enable; output is all-zero when low
//   onehot_o : one-hot strobe, bit idx_i set when enabled
// -----------------------------------------------------------------------------
module cid_onehot_dec
    import clause_io_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int WIDTH_CID   = 3
) (
    input  logic [WIDTH_CID-1:0]   idx_i,
    input  logic                   en_i,
    output logic [NUM_CLAUSES-1:0] onehot_o
);

    localparam logic [NUM_CLAUSES-1:0] ONE_VEC = {{(NUM_CLAUSES-1){1'b0}}, 1'b1};

    // Shift a single set bit into the indexed slot position.
    always_comb begin
        onehot_o = {NUM_CLAUSES{1'b0}};
        if (en_i) begin
            onehot_o = ONE_VEC << idx_i;
        end else begin
            onehot_o = {NUM_CLAUSES{1'b0}};
        end
    end

endmodule

// File: rtl/clause_array_io_ctrl.sv
// -----------------------------------------------------------------------------
// clause_array_io_ctrl
// Load/update sequencer for a clause array.
//   Load  : accepts clauses on ld_valid_i/ld_ready_o and writes them to slots
//           0..count-1 with one-hot wr_o plus clause_o/clause_len_o.
//   Update: strobes rd_o per slot, captures the array's OR-reduced word and the
//           slot's length one cycle later and presents them on up_valid_o /
//           up_ready_i with the slot index on up_cid_o.
// Ports:
//   clk, rst (async, active-low)
//   start_load_i, start_update_i, num_clauses_i   : pass control
//   ld_valid_i, ld_ready_o, ld_clause_i, ld_len_i : load stream
//   up_valid_o, up_ready_i, up_clause_o, up_len_o, up_cid_o : update stream
//   wr_o, rd_o, clause_o, clause_len_o            : array write/read side
//   clause_i, clause_len_i                        : array read-back
//   busy_o, done_o                                : status
// Build option: CLAUSE_IO_SKIP_EMPTY_EN -- when defined, slots whose length
// reads back as zero are skipped during update and never emitted.
// All outputs are registered.
// -----------------------------------------------------------------------------
module clause_array_io_ctrl
    import clause_io_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int NUM_VARS    = CLAUSE_W / 2,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_CID   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_load_i,
    input  logic                               start_update_i,
    input  logic [WIDTH_CID:0]                 num_clauses_i,
    input  logic                               ld_valid_i,
    output logic                               ld_ready_o,
    input  logic [2*NUM_VARS-1:0]              ld_clause_i,
    input  logic [WIDTH_C_LEN-1:0]             ld_len_i,
    output logic                               up_valid_o,
    input  logic                               up_ready_i,
    output logic [2*NUM_VARS-1:0]              up_clause_o,
    output logic [WIDTH_C_LEN-1:0]             up_len_o,
    output logic [WIDTH_CID-1:0]               up_cid_o,
    output logic [NUM_CLAUSES-1:0]             wr_o,
    output logic [NUM_CLAUSES-1:0]             rd_o,
    output logic [2*NUM_VARS-1:0]              clause_o,
    output logic [WIDTH_C_LEN-1:0]             clause_len_o,
    input  logic [2*NUM_VARS-1:0]              clause_i,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int CW = 2 * NUM_VARS;
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_e                 state_q, state_d;
    logic [WIDTH_CID-1:0]   cid_q, cid_d;
    logic [WIDTH_CID:0]     count_q, count_d;
    logic [1:0]             lat_q, lat_d;
    logic [CW-1:0]          clause_q, clause_d;
    logic [WIDTH_C_LEN-1:0] clause_len_q, clause_len_d;
    logic                   up_valid_q, up_valid_d;
    logic [CW-1:0]          up_clause_q, up_clause_d;
    logic [WIDTH_C_LEN-1:0] up_len_q, up_len_d;
    logic [WIDTH_CID-1:0]   up_cid_q, up_cid_d;
    logic [NUM_CLAUSES-1:0] wr_q, rd_q;
    logic                   ld_ready_q, busy_q, done_q;

    logic                   ld_hs_s;
    logic                   last_s;
    logic [WIDTH_C_LEN-1:0] len_sel_s;
    logic [WIDTH_CID:0]     start_count_s;
    logic [NUM_CLAUSES-1:0] wr_dec_s, rd_dec_s;
    logic                   rd_en_s;

    assign ld_hs_s       = ld_valid_i & ld_ready_q & (state_q == ST_LOAD);
    // count is never zero inside LOAD/RD/CAP/OUT, so count-1 cannot underflow there.
    assign last_s        = ({1'b0, cid_q} == (count_q - {{WIDTH_CID{1'b0}}, 1'b1}));
    assign len_sel_s     = clause_len_i[cid_q*WIDTH_C_LEN +: WIDTH_C_LEN];
    assign start_count_s = (WIDTH_CID+1)'(clamp_count(32'(num_clauses_i), 32'(NUM_CLAUSES)));
    // The read strobe is registered, so it is decoded from the state being entered.
    assign rd_en_s       = (state_d == ST_RD);

    cid_onehot_dec #(
        .NUM_CLAUSES (NUM_CLAUSES),
        .WIDTH_CID   (WIDTH_CID)
    ) u_wr_dec (
        .idx_i    (cid_q),
        .en_i     (ld_hs_s),
        .onehot_o (wr_dec_s)
    );

    cid_onehot_dec #(
        .NUM_CLAUSES (NUM_CLAUSES),
        .WIDTH_CID   (WIDTH_CID)
    ) u_rd_dec (
        .idx_i    (cid_d),
        .en_i     (rd_en_s),
        .onehot_o (rd_dec_s)
    );

    // Next-state and datapath update for the shared load/update sequencer.
    always_comb begin
        state_d      = state_q;
        cid_d        = cid_q;
        count_d      = count_q;
        lat_d        = lat_q;
        clause_d     = clause_q;
        clause_len_d = clause_len_q;
        up_valid_d   = up_valid_q;
        up_clause_d  = up_clause_q;
        up_len_d     = up_len_q;
        up_cid_d     = up_cid_q;

        case (state_q)
            ST_IDLE: begin
                // Load has priority; a simultaneous update start is dropped.
                if (start_load_i) begin
                    count_d = start_count_s;
                    cid_d   = {WIDTH_CID{1'b0}};
                    if (start_count_s == {(WIDTH_CID+1){1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (start_update_i) begin
                    count_d = start_count_s;
                    cid_d   = {WIDTH_CID{1'b0}};
                    if (start_count_s == {(WIDTH_CID+1){1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (ld_hs_s) begin
                    clause_d     = ld_clause_i;
                    clause_len_d = ld_len_i;
                    // cid stops at the last slot instead of wrapping.
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        cid_d = cid_q + WIDTH_CID'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RD: begin
                lat_d   = 2'd0;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                // Wait out the array read latency before sampling clause_i.
                if (lat_q == LAT_LAST) begin
`ifdef CLAUSE_IO_SKIP_EMPTY_EN
                    if (len_sel_s == {WIDTH_C_LEN{1'b0}}) begin
                        if (last_s) begin
                            state_d = ST_DONE;
                        end else begin
                            cid_d   = cid_q + WIDTH_CID'(1);
                            state_d = ST_RD;
                        end
                    end else begin
                        up_clause_d = clause_i;
                        up_len_d    = len_sel_s;
                        up_cid_d    = cid_q;
                        up_valid_d  = 1'b1;
                        state_d     = ST_OUT;
                    end
`else
                    up_clause_d = clause_i;
                    up_len_d    = len_sel_s;
                    up_cid_d    = cid_q;
                    up_valid_d  = 1'b1;
                    state_d     = ST_OUT;
`endif
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_OUT: begin
                if (up_ready_i) begin
                    up_valid_d = 1'b0;
                    if (last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        cid_d   = cid_q + WIDTH_CID'(1);
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_DONE: begin
                cid_d   = {WIDTH_CID{1'b0}};
                count_d = {(WIDTH_CID+1){1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Array write data is only held while the FSM is in LOAD, plus the one
        // cycle in which the final write strobe is presented.
        if (state_q != ST_LOAD) begin
            clause_d     = {CW{1'b0}};
            clause_len_d = {WIDTH_C_LEN{1'b0}};
        end else begin
            clause_d     = clause_d;
            clause_len_d = clause_len_d;
        end
    end

    // State and registered outputs; reset aborts any pass and clears all strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cid_q        <= {WIDTH_CID{1'b0}};
            count_q      <= {(WIDTH_CID+1){1'b0}};
            lat_q        <= 2'd0;
            clause_q     <= {CW{1'b0}};
            clause_len_q <= {WIDTH_C_LEN{1'b0}};
            up_valid_q   <= 1'b0;
            up_clause_q  <= {CW{1'b0}};
            up_len_q     <= {WIDTH_C_LEN{1'b0}};
            up_cid_q     <= {WIDTH_CID{1'b0}};
            wr_q         <= {NUM_CLAUSES{1'b0}};
            rd_q         <= {NUM_CLAUSES{1'b0}};
            ld_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cid_q        <= cid_d;
            count_q      <= count_d;
            lat_q        <= lat_d;
            clause_q     <= clause_d;
            clause_len_q <= clause_len_d;
            up_valid_q   <= up_valid_d;
            up_clause_q  <= up_clause_d;
            up_len_q     <= up_len_d;
            up_cid_q     <= up_cid_d;
            wr_q         <= wr_dec_s;
            rd_q         <= rd_dec_s;
            ld_ready_q   <= (state_d == ST_LOAD);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_q == ST_DONE);
        end
    end

    assign ld_ready_o   = ld_ready_q;
    assign up_valid_o   = up_valid_q;
    assign up_clause_o  = up_clause_q;
    assign up_len_o     = up_len_q;
    assign up_cid_o     = up_cid_q;
    assign wr_o         = wr_q;
    assign rd_o         = rd_q;
    assign clause_o     = clause_q;
    assign clause_len_o = clause_len_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_clause_array_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clause_array_io_ctrl
// Self-checking bench for clause_array_io_ctrl (default parameters).
// Load writes and update items are predicted into queues when the stimulus is
// driven and compared when the DUT presents them. Table-driven load passes are
// followed by hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clause_array_io_ctrl;

    localparam int NC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load_i, start_update_i;
    logic [3:0]  num_clauses_i;
    logic        ld_valid_i, ld_ready_o;
    logic [15:0] ld_clause_i;
    logic [3:0]  ld_len_i;
    logic        up_valid_o, up_ready_i;
    logic [15:0] up_clause_o;
    logic [3:0]  up_len_o;
    logic [2:0]  up_cid_o;
    logic [7:0]  wr_o, rd_o;
    logic [15:0] clause_o;
    logic [3:0]  clause_len_o;
    logic [15:0] clause_i;
    logic [31:0] clause_len_i;
    logic        busy_o, done_o;

    clause_array_io_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_load_i   (start_load_i),
        .start_update_i (start_update_i),
        .num_clauses_i  (num_clauses_i),
        .ld_valid_i     (ld_valid_i),
        .ld_ready_o     (ld_ready_o),
        .ld_clause_i    (ld_clause_i),
        .ld_len_i       (ld_len_i),
        .up_valid_o     (up_valid_o),
        .up_ready_i     (up_ready_i),
        .up_clause_o    (up_clause_o),
        .up_len_o       (up_len_o),
        .up_cid_o       (up_cid_o),
        .wr_o           (wr_o),
        .rd_o           (rd_o),
        .clause_o       (clause_o),
        .clause_len_o   (clause_len_o),
        .clause_i       (clause_i),
        .clause_len_i   (clause_len_i),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    // Array model: one-cycle read latency, OR-reduced word is a fixed pattern.
    always @(posedge clk) begin
        clause_i <= (rd_o != 8'h00) ? 16'hA5A5 : 16'h0000;
    end

    typedef struct packed {
        logic [7:0]  strobe;
        logic [15:0] clause;
        logic [3:0]  len;
    } wr_exp_t;

    typedef struct packed {
        logic [2:0]  cid;
        logic [3:0]  len;
        logic [15:0] clause;
    } up_exp_t;

    typedef struct {
        logic [3:0] num;
        int         exp_cnt;
        logic [7:0] exp_last;
        int         exp_busy;
    } ld_vec_t;

    wr_exp_t    wq[$];
    up_exp_t    uq[$];
    int         checks = 0;
    int         errors = 0;
    int         wr_cnt, rd_cnt, busy_cnt, done_cnt, up_cnt, cid_m;
    logic [7:0] last_wr;
    ld_vec_t    vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_pass();
        wq.delete();
        uq.delete();
        wr_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0; up_cnt = 0; cid_m = 0;
        last_wr = 8'h00;
    endtask

    // One clock: monitor/scoreboard at the falling edge, return 1ns after the rising edge.
    task automatic tick();
        wr_exp_t w;
        up_exp_t u;
        @(negedge clk);
        chk("strobe_onehot_excl",
            32'($onehot0(wr_o) && $onehot0(rd_o) && !((wr_o != 8'h00) && (rd_o != 8'h00))), 32'd1);
        if (wr_o != 8'h00) begin
            wr_cnt++;
            last_wr = wr_o;
            if (wq.size() == 0) begin
                chk("wr_unexpected", 32'(wr_o), 32'd0);
            end else begin
                w = wq.pop_front();
                chk("wr_o", 32'(wr_o), 32'(w.strobe));
                chk("clause_o", 32'(clause_o), 32'(w.clause));
                chk("clause_len_o", 32'(clause_len_o), 32'(w.len));
            end
        end
        if (ld_valid_i && ld_ready_o) begin
            w.strobe = (cid_m < NC) ? (8'h01 << cid_m) : 8'h00;
            w.clause = ld_clause_i;
            w.len    = ld_len_i;
            wq.push_back(w);
            cid_m++;
        end
        if (rd_o != 8'h00) rd_cnt++;
        if (busy_o) busy_cnt++;
        if (done_o) done_cnt++;
        if (up_valid_o && up_ready_i) begin
            up_cnt++;
            if (uq.size() == 0) begin
                chk("up_unexpected", 32'(up_cid_o), 32'hFFFF_FFFF);
            end else begin
                u = uq.pop_front();
                chk("up_cid_o", 32'(up_cid_o), 32'(u.cid));
                chk("up_len_o", 32'(up_len_o), 32'(u.len));
                chk("up_clause_o", 32'(up_clause_o), 32'(u.clause));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [3:0] num, input int exp_cnt, input logic [7:0] exp_last,
                            input int exp_busy, input bit gaps);
        start_pass();
        num_clauses_i = num;
        start_load_i  = 1'b1;
        tick();
        start_load_i  = 1'b0;
        for (int c = 0; c < 200 && done_cnt == 0; c++) begin
            ld_valid_i  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_clause_i = 16'($urandom);
            ld_len_i    = 4'($urandom);
            tick();
        end
        chk("load_done_seen", 32'(done_cnt), 32'd1);
        tick();
        tick();
        ld_valid_i = 1'b0;
        chk("load_write_count", 32'(wr_cnt), 32'(exp_cnt));
        chk("load_last_wr", 32'(last_wr), 32'(exp_last));
        chk("load_queue_empty", 32'(wq.size()), 32'd0);
        chk("load_done_once", 32'(done_cnt), 32'd1);
        chk("load_ready_after", 32'(ld_ready_o), 32'd0);
        chk("load_busy_after", 32'(busy_o), 32'd0);
        if (exp_busy >= 0) chk("load_busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        logic [3:0] lens [4];
        int         exp_up;

        vecs[0] = '{num: 4'd3,  exp_cnt: 3, exp_last: 8'h04, exp_busy: 4};
        vecs[1] = '{num: 4'd12, exp_cnt: 8, exp_last: 8'h80, exp_busy: 9};
        vecs[2] = '{num: 4'd1,  exp_cnt: 1, exp_last: 8'h01, exp_busy: 2};
        vecs[3] = '{num: 4'd0,  exp_cnt: 0, exp_last: 8'h00, exp_busy: 1};
        vecs[4] = '{num: 4'd15, exp_cnt: 8, exp_last: 8'h80, exp_busy: 9};

        rst = 1'b0;
        start_load_i = 1'b0; start_update_i = 1'b0; num_clauses_i = 4'd0;
        ld_valid_i = 1'b0; ld_clause_i = 16'h0000; ld_len_i = 4'd0;
        up_ready_i = 1'b0; clause_len_i = 32'h0;
        start_pass();

        // Reset state
        #12;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready_o), 32'd0);
        chk("rst_up_valid", 32'(up_valid_o), 32'd0);
        chk("rst_wr", 32'(wr_o), 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_clause", 32'(clause_o), 32'd0);
        chk("rst_clause_len", 32'(clause_len_o), 32'd0);
        chk("rst_up_clause", 32'(up_clause_o), 32'd0);
        chk("rst_up_len", 32'(up_len_o), 32'd0);
        chk("rst_up_cid", 32'(up_cid_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fixed three-clause load with per-cycle strobe checks
        start_pass();
        num_clauses_i = 4'd3;
        start_load_i  = 1'b1;
        tick();
        start_load_i  = 1'b0;
        chk("fix_ready", 32'(ld_ready_o), 32'd1);
        ld_valid_i = 1'b1; ld_len_i = 4'd1; ld_clause_i = 16'h0001;
        tick();
        chk("fix_wr0", 32'(wr_o), 32'h01);
        chk("fix_cl0", 32'(clause_o), 32'h0001);
        ld_len_i = 4'd2; ld_clause_i = 16'h0030;
        tick();
        chk("fix_wr1", 32'(wr_o), 32'h02);
        chk("fix_cl1", 32'(clause_o), 32'h0030);
        ld_len_i = 4'd3; ld_clause_i = 16'h0500;
        tick();
        chk("fix_wr2", 32'(wr_o), 32'h04);
        chk("fix_cl2", 32'(clause_o), 32'h0500);
        chk("fix_ready_drop", 32'(ld_ready_o), 32'd0);
        tick();
        chk("fix_done", 32'(done_o), 32'd1);
        chk("fix_clause_clr", 32'(clause_o), 32'd0);
        tick();
        ld_valid_i = 1'b0;
        chk("fix_done_low", 32'(done_o), 32'd0);
        chk("fix_done_once", 32'(done_cnt), 32'd1);
        chk("fix_wr_count", 32'(wr_cnt), 32'd3);

        // Table-driven load passes
        for (int i = 0; i < 5; i++) begin
            run_load(vecs[i].num, vecs[i].exp_cnt, vecs[i].exp_last, vecs[i].exp_busy, 1'b0);
        end
        run_load(4'd8, 8, 8'h80, -1, 1'b1);

        // Update pass of two with a stalled consumer
        start_pass();
        clause_len_i = {24'h9E_1C4B, 4'd3, 4'd7};
        uq.push_back('{cid: 3'd0, len: 4'd7, clause: 16'hA5A5});
        uq.push_back('{cid: 3'd1, len: 4'd3, clause: 16'hA5A5});
        num_clauses_i  = 4'd2;
        up_ready_i     = 1'b0;
        start_update_i = 1'b1;
        tick();
        start_update_i = 1'b0;
        chk("upd_rd0", 32'(rd_o), 32'h01);
        tick();
        chk("upd_rd_single", 32'(rd_o), 32'h00);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("upd_hold_valid", 32'(up_valid_o), 32'd1);
            chk("upd_hold_clause", 32'(up_clause_o), 32'hA5A5);
            chk("upd_hold_len", 32'(up_len_o), 32'd7);
            chk("upd_hold_cid", 32'(up_cid_o), 32'd0);
            tick();
        end
        up_ready_i = 1'b1;
        for (int c = 0; c < 50 && done_cnt == 0; c++) tick();
        chk("upd_done_seen", 32'(done_cnt), 32'd1);
        chk("upd_items", 32'(up_cnt), 32'd2);
        chk("upd_reads", 32'(rd_cnt), 32'd2);
        chk("upd_queue_empty", 32'(uq.size()), 32'd0);
        chk("upd_valid_after", 32'(up_valid_o), 32'd0);

        // Simultaneous starts, then an update start while busy
        start_pass();
        num_clauses_i  = 4'd3;
        start_load_i   = 1'b1;
        start_update_i = 1'b1;
        ld_valid_i     = 1'b1;
        tick();
        start_load_i   = 1'b0;
        start_update_i = 1'b0;
        tick();
        start_update_i = 1'b1;
        tick();
        start_update_i = 1'b0;
        for (int c = 0; c < 50 && done_cnt == 0; c++) tick();
        ld_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("both_writes", 32'(wr_cnt), 32'd3);
        chk("both_no_reads", 32'(rd_cnt), 32'd0);
        chk("both_no_items", 32'(up_cnt), 32'd0);
        chk("both_done_once", 32'(done_cnt), 32'd1);
        chk("both_idle", 32'(busy_o), 32'd0);

        // Reset between the 2nd and 3rd load handshakes
        start_pass();
        num_clauses_i = 4'd5;
        ld_valid_i    = 1'b1;
        start_load_i  = 1'b1;
        tick();
        start_load_i  = 1'b0;
        tick();
        tick();
        chk("rstmid_wr_before", 32'(wr_o), 32'h02);
        chk("rstmid_busy_before", 32'(busy_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_wr", 32'(wr_o), 32'd0);
        chk("rstmid_busy", 32'(busy_o), 32'd0);
        chk("rstmid_ready", 32'(ld_ready_o), 32'd0);
        chk("rstmid_clause", 32'(clause_o), 32'd0);
        ld_valid_i = 1'b0;
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        run_load(4'd2, 2, 8'h02, 3, 1'b0);

        // Zero-length slots on the update stream
        start_pass();
        lens[0] = 4'd0; lens[1] = 4'd5; lens[2] = 4'd0; lens[3] = 4'd2;
        clause_len_i = {16'h0000, lens[3], lens[2], lens[1], lens[0]};
        exp_up = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef CLAUSE_IO_SKIP_EMPTY_EN
            if (lens[k] != 4'd0) begin
                uq.push_back('{cid: 3'(k), len: lens[k], clause: 16'hA5A5});
                exp_up++;
            end
`else
            uq.push_back('{cid: 3'(k), len: lens[k], clause: 16'hA5A5});
            exp_up++;
`endif
        end
        num_clauses_i  = 4'd4;
        up_ready_i     = 1'b1;
        start_update_i = 1'b1;
        tick();
        start_update_i = 1'b0;
        for (int c = 0; c < 80 && done_cnt == 0; c++) tick();
        chk("empty_done_seen", 32'(done_cnt), 32'd1);
        chk("empty_items", 32'(up_cnt), 32'(exp_up));
        chk("empty_reads", 32'(rd_cnt), 32'd4);
        chk("empty_queue", 32'(uq.size()), 32'd0);
        up_ready_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
